jk_excite_driver: RTL and testbench

- Inverse of the JK storage element: given a desired next-state word, computes per-bit J/K excitation from the JK excitation table.
- Drives an external WIDTH-bit bank of JK elements for one enable cycle, waits a settle interval, then reads back Q and checks it against the target.
- Sits between a pattern source (valid/ready) and a JK register bank.
- Provides the stimulus/encode side for JK latch and flip-flop blocks in sequential test harnesses.

---
 rtl/jk_excite_driver.sv | 99 +++++++++
 tb/tb_jk_excite_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: turns a target word into JK excitation codes,
// strobes an external JK bank once, then checks the readback.
module jk_excite_driver #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int DC_POLICY   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic             en_out,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);
  localparam logic [WIDTH-1:0] DC =
    (DC_POLICY != 0) ? '1 : '0;

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] j_calc;
  logic [WIDTH-1:0] k_calc;

  // Excitation: J matters only where Q=0, K only where Q=1.
  always_comb begin
    j_calc = (~q_in & tgt_data) | (q_in & DC);
    k_calc = (q_in & ~tgt_data) | (~q_in & DC);
  end

  // Transaction sequencer with registered bank-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      cnt       <= '0;
      tgt_ready <= 1'b0;
      en_out    <= 1'b0;
      j_out     <= '0;
      k_out     <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tgt_ready <= 1'b1;
          if (tgt_valid && tgt_ready) begin
            tgt       <= tgt_data;
            j_out     <= j_calc;
            k_out     <= k_calc;
            en_out    <= 1'b1;
            tgt_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          en_out <= 1'b0;
          j_out  <= '0;
          k_out  <= '0;
          cnt    <= HOLD;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (cnt <= 4'd1) begin
            done     <= 1'b1;
            mismatch <= (q_in != tgt);
            if ((q_in != tgt) && (err_count != 8'hFF))
              err_count <= err_count + 8'd1;
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          tgt_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: three driver configurations, each
// closing the loop through a behavioural JK bank.
module tb_jk_excite_driver;

  logic       clk;
  logic       rst     [3];
  logic       valid   [3];
  logic [3:0] tdata   [3];
  logic       rdy     [3];
  logic       en      [3];
  logic [3:0] jo      [3];
  logic [3:0] ko      [3];
  logic       done    [3];
  logic       mism    [3];
  logic [7:0] errc    [3];
  logic [3:0] bq      [3];
  logic [3:0] ign     [3];
  logic [3:0] pre_val [3];
  logic       pre_req [3];

  int vectors = 0;
  int fails   = 0;
  int errm    [3];

  jk_excite_driver #(.WIDTH(4), .HOLD_CYCLES(1), .DC_POLICY(0)) u0 (
    .clk(clk), .rst(rst[0]), .tgt_valid(valid[0]),
    .tgt_data(tdata[0]), .tgt_ready(rdy[0]), .q_in(bq[0]),
    .en_out(en[0]), .j_out(jo[0]), .k_out(ko[0]),
    .done(done[0]), .mismatch(mism[0]), .err_count(errc[0])
  );

  jk_excite_driver #(.WIDTH(4), .HOLD_CYCLES(1), .DC_POLICY(1)) u1 (
    .clk(clk), .rst(rst[1]), .tgt_valid(valid[1]),
    .tgt_data(tdata[1]), .tgt_ready(rdy[1]), .q_in(bq[1]),
    .en_out(en[1]), .j_out(jo[1]), .k_out(ko[1]),
    .done(done[1]), .mismatch(mism[1]), .err_count(errc[1])
  );

  jk_excite_driver #(.WIDTH(4), .HOLD_CYCLES(3), .DC_POLICY(0)) u2 (
    .clk(clk), .rst(rst[2]), .tgt_valid(valid[2]),
    .tgt_data(tdata[2]), .tgt_ready(rdy[2]), .q_in(bq[2]),
    .en_out(en[2]), .j_out(jo[2]), .k_out(ko[2]),
    .done(done[2]), .mismatch(mism[2]), .err_count(errc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK bank clocked by en_out; masked bits never update.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (pre_req[u]) begin
        bq[u] <= pre_val[u];
      end else if (en[u]) begin
        for (int i = 0; i < 4; i++) begin
          if (!ign[u][i]) begin
            case ({jo[u][i], ko[u][i]})
              2'b10: bq[u][i] <= 1'b1;
              2'b01: bq[u][i] <= 1'b0;
              2'b11: bq[u][i] <= ~bq[u][i];
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input int u, input logic [3:0] v);
    pre_val[u] = v;
    pre_req[u] = 1'b1;
    @(negedge clk);
    pre_req[u] = 1'b0;
  endtask

  // Excitation table lookup, one bit at a time.
  task automatic excite(input logic [3:0] cur, input logic [3:0] t,
                        input logic dc, output logic [3:0] ej,
                        output logic [3:0] ek);
    for (int i = 0; i < 4; i++) begin
      case ({cur[i], t[i]})
        2'b00:   begin ej[i] = 1'b0; ek[i] = dc;   end
        2'b01:   begin ej[i] = 1'b1; ek[i] = dc;   end
        2'b10:   begin ej[i] = dc;   ek[i] = 1'b1; end
        default: begin ej[i] = dc;   ek[i] = 1'b0; end
      endcase
    end
  endtask

  task automatic run(input int u, input logic [3:0] t);
    logic [3:0] cur, ej, ek, eq;
    logic       dc, em;
    int         h, w;
    h  = (u == 2) ? 3 : 1;
    dc = (u == 1);
    w  = 0;
    while (!rdy[u] && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[u]) begin
      chk("ready_timeout", 32'(rdy[u]), 32'd1);
      return;
    end
    cur = bq[u];
    excite(cur, t, dc, ej, ek);
    eq = (t & ~ign[u]) | (cur & ign[u]);
    em = (eq != t);
    if (em) errm[u] = (errm[u] >= 255) ? 255 : errm[u] + 1;
    valid[u] = 1'b1;
    tdata[u] = t;
    @(negedge clk);
    valid[u] = 1'b0;
    chk("drive_en", 32'(en[u]), 32'd1);
    chk("drive_j", 32'(jo[u]), 32'(ej));
    chk("drive_k", 32'(ko[u]), 32'(ek));
    chk("drive_busy", 32'(rdy[u]), 32'd0);
    for (int s = 0; s < h; s++) begin
      @(negedge clk);
      chk("settle_en", 32'(en[u]), 32'd0);
      chk("settle_jk", 32'({jo[u], ko[u]}), 32'd0);
      chk("settle_done", 32'(done[u]), 32'd0);
    end
    @(negedge clk);
    chk("check_done", 32'(done[u]), 32'd1);
    chk("check_mismatch", 32'(mism[u]), 32'(em));
    chk("check_err", 32'(errc[u]), 32'(errm[u]));
    @(negedge clk);
    chk("post_done", 32'(done[u]), 32'd0);
    chk("post_ready", 32'(rdy[u]), 32'd1);
    chk("post_mismatch_hold", 32'(mism[u]), 32'(em));
  endtask

  initial begin
    int acc[$];
    int ens[$];
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      valid[u] = 1'b0;
      tdata[u] = '0;
      ign[u] = '0;
      pre_val[u] = '0;
      pre_req[u] = 1'b1;
      errm[u] = 0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      pre_req[u] = 1'b0;
      chk("rst_ready", 32'(rdy[u]), 32'd0);
      chk("rst_en", 32'(en[u]), 32'd0);
      chk("rst_jk", 32'({jo[u], ko[u]}), 32'd0);
      chk("rst_done", 32'({done[u], mism[u]}), 32'd0);
      chk("rst_err", 32'(errc[u]), 32'd0);
      rst[u] = 1'b0;
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk("ready_after_rst", 32'(rdy[u]), 32'd1);

    preset(0, 4'b0000);
    run(0, 4'b1010);
    preset(0, 4'b1100);
    run(0, 4'b0110);
    preset(1, 4'b1100);
    run(1, 4'b0110);
    chk("dc1_readback", 32'(bq[1]), 32'h6);

    ign[0] = 4'b0001;
    preset(0, 4'b0000);
    for (int n = 0; n < 301; n++) run(0, 4'b0001);
    chk("err_saturated", 32'(errc[0]), 32'd255);
    ign[0] = 4'b0000;

    for (int n = 0; n < 60; n++) begin
      int u;
      u = int'($urandom_range(0, 2));
      ign[u] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      preset(u, 4'($urandom));
      run(u, 4'($urandom));
    end
    for (int u = 0; u < 3; u++) ign[u] = 4'b0000;

    ign[2] = 4'b1000;
    preset(2, 4'b0000);
    run(2, 4'b1000);
    ign[2] = 4'b0000;
    valid[2] = 1'b1;
    tdata[2] = 4'b0101;
    @(negedge clk);
    valid[2] = 1'b0;
    chk("abort_drive_en", 32'(en[2]), 32'd1);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("abort_en", 32'(en[2]), 32'd0);
    chk("abort_done", 32'(done[2]), 32'd0);
    chk("abort_err", 32'(errc[2]), 32'd0);
    chk("abort_ready", 32'(rdy[2]), 32'd0);
    rst[2] = 1'b0;
    errm[2] = 0;
    @(negedge clk);
    chk("abort_ready_rise", 32'(rdy[2]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done[2], en[2]}), 32'd0);
    end

    tdata[2] = 4'b0011;
    valid[2] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (rdy[2] && valid[2]) acc.push_back(c);
      if (en[2]) ens.push_back(c);
      @(negedge clk);
    end
    valid[2] = 1'b0;
    chk("tp_accepts", 32'(acc.size()), 32'd4);
    chk("tp_strobes", 32'(ens.size()), 32'd4);
    for (int k = 0; k < acc.size() && k < ens.size(); k++) begin
      chk("tp_accept_cycle", 32'(acc[k]), 32'(6 * k));
      chk("tp_strobe_cycle", 32'(ens[k]), 32'(6 * k + 1));
    end
    repeat (8) @(negedge clk);
    chk("tp_err", 32'(errc[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
